// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO controller constants and types used by the accelerator output packer.
package fifo_ctrl_pkg;

   localparam int unsigned data_width     = 64;
   localparam int unsigned acc_width      = 16;
   localparam int unsigned pack_ratio     = data_width / acc_width;
   localparam int unsigned idle_cnt_width = 14;

   typedef logic [$clog2(pack_ratio):0]   beat_cnt_t;
   typedef logic [idle_cnt_width-1:0]     idle_cnt_t;

endpackage

// File: rtl/acc_packer_idle_timer.sv
// Saturating idle-cycle counter; pulses o_expire in the cycle the count reaches i_limit.
module acc_packer_idle_timer
   import fifo_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_arm,
   input  logic      i_clear,
   input  idle_cnt_t i_limit,
   output logic      o_expire
);

   idle_cnt_t r_count;
   idle_cnt_t w_count_inc;
   idle_cnt_t w_count_d;

   always_comb begin
      w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;
      w_count_d   = r_count;
      if (i_clear) begin
         w_count_d = '0;
      end else if (i_arm) begin
         w_count_d = w_count_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_d;
      end
   end

   // Fires once: a saturated counter can no longer step onto the limit.
   assign o_expire = i_arm && !i_clear && (i_limit != '0) && (r_count != '1) &&
                     (w_count_inc == i_limit);

endmodule

// File: rtl/acc_out_packer.sv
// Packs AccWidth accelerator beats into DataWidth words with flush/timeout for partial words.
// Optional stat_words/stat_partial counters are enabled by ACC_OUT_PACKER_STATS_EN.
module acc_out_packer
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned  DataWidth = data_width,
   parameter int unsigned  AccWidth  = acc_width,
   localparam int unsigned PackRatio = DataWidth / AccWidth
)(
   input  logic                         clk,
   input  logic                         rst,
   input  idle_cnt_t                    flush_cycles,
   input  logic                         flush_i,
   input  logic                         acc_valid,
   output logic                         acc_ready,
   input  logic [AccWidth-1:0]          acc_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DataWidth-1:0]         out_data,
   output logic [$clog2(PackRatio):0]   out_beats
`ifdef ACC_OUT_PACKER_STATS_EN
   ,
   output logic [31:0]                  stat_words,
   output logic [31:0]                  stat_partial
`endif
);

   localparam int unsigned     CntW    = $clog2(PackRatio) + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(PackRatio);

   logic [DataWidth-1:0] r_acc;
   logic [DataWidth-1:0] w_acc_d;
   logic [CntW-1:0]      r_cnt;
   logic [CntW-1:0]      w_cnt_d;
   logic                 r_flush_pend;
   logic                 w_flush_pend_d;

   logic                 r_out_valid;
   logic [DataWidth-1:0] r_out_data;
   logic [CntW-1:0]      r_out_beats;

   logic                 w_has_data;
   logic                 w_accept;
   logic                 w_emit;
   logic                 w_xfer;
   logic                 w_arm;
   logic                 w_expire;

   assign w_has_data = (r_cnt != '0);
   assign acc_ready  = (r_cnt < FullCnt) && !r_flush_pend;
   assign w_accept   = acc_valid && acc_ready;
   assign w_emit     = (r_cnt == FullCnt) || (w_has_data && r_flush_pend);
   // Output register loads while it is empty or being drained this cycle.
   assign w_xfer     = w_emit && (!r_out_valid || out_ready);
   assign w_arm      = w_has_data && !r_flush_pend && !w_accept;

   acc_packer_idle_timer u_idle_timer (
      .clk      (clk),
      .rst      (rst),
      .i_arm    (w_arm),
      .i_clear  (w_accept || w_xfer),
      .i_limit  (flush_cycles),
      .o_expire (w_expire)
   );

   // Accept and transfer are mutually exclusive: acc_ready is low whenever emit can hold.
   always_comb begin
      w_acc_d = r_acc;
      w_cnt_d = r_cnt;
      if (w_xfer) begin
         w_acc_d = '0;
         w_cnt_d = '0;
      end else if (w_accept) begin
         for (int k = 0; k < PackRatio; k++) begin
            if (r_cnt == CntW'(k)) begin
               w_acc_d[k*AccWidth +: AccWidth] = acc_data;
            end
         end
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_flush_pend_d = r_flush_pend;
      if (w_xfer) begin
         w_flush_pend_d = 1'b0;
      end else if ((flush_i && (w_has_data || w_accept)) || w_expire) begin
         w_flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_acc        <= w_acc_d;
         r_cnt        <= w_cnt_d;
         r_flush_pend <= w_flush_pend_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_beats <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_acc;
         r_out_beats <= r_cnt;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_beats = r_out_beats;

`ifdef ACC_OUT_PACKER_STATS_EN
   logic [31:0] r_stat_words;
   logic [31:0] r_stat_partial;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_words   <= '0;
         r_stat_partial <= '0;
      end else if (w_xfer) begin
         r_stat_words <= r_stat_words + 32'd1;
         if (r_cnt != FullCnt) begin
            r_stat_partial <= r_stat_partial + 32'd1;
         end
      end
   end

   assign stat_words   = r_stat_words;
   assign stat_partial = r_stat_partial;
`endif

endmodule

// File: tb/tb_acc_out_packer.sv
// Scoreboard bench for acc_out_packer (AccWidth=16, DataWidth=64).
module tb_acc_out_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] flush_cycles;
   logic        flush_i;
   logic        acc_valid;
   logic        acc_ready;
   logic [15:0] acc_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [2:0]  out_beats;
`ifdef ACC_OUT_PACKER_STATS_EN
   logic [31:0] stat_words;
   logic [31:0] stat_partial;
`endif

   always #5 clk = ~clk;

   acc_out_packer dut (
      .clk          (clk),
      .rst          (rst),
      .flush_cycles (flush_cycles),
      .flush_i      (flush_i),
      .acc_valid    (acc_valid),
      .acc_ready    (acc_ready),
      .acc_data     (acc_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_beats    (out_beats)
`ifdef ACC_OUT_PACKER_STATS_EN
      ,
      .stat_words   (stat_words),
      .stat_partial (stat_partial)
`endif
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_words  = 0;
   int          words_before;
   logic [66:0] exp_q[$];
   logic [66:0] sb_entry;
   logic [63:0] m_acc;
   int          m_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected word = whatever beats the model has collected so far.
   task automatic push_model();
      if (m_cnt > 0) exp_q.push_back({3'(m_cnt), m_acc});
      m_acc = '0;
      m_cnt = 0;
   endtask

   task automatic send(input logic [15:0] d);
      bit ok;
      ok        = 1'b0;
      acc_valid = 1'b1;
      acc_data  = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (acc_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
      if (!ok) begin
         check_eq("send_timeout", 64'(acc_ready), 64'd1);
      end else begin
         m_acc[m_cnt*16 +: 16] = d;
         m_cnt++;
         if (m_cnt == 4) push_model();
      end
   endtask

   task automatic flush_pulse();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      push_model();
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_words++;
         if (exp_q.size() == 0) begin
            check_eq("sb_empty", 64'(exp_q.size()), 64'd1);
         end else begin
            sb_entry = exp_q.pop_front();
            check_eq("sb_data", out_data, sb_entry[63:0]);
            check_eq("sb_beats", 64'(out_beats), 64'(sb_entry[66:64]));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      out_ready    = 1'b1;
      flush_cycles = '0;
      flush_i      = 1'b0;
      acc_valid    = 1'b0;
      acc_data     = '0;
      m_acc        = '0;
      m_cnt        = 0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_data", out_data, 64'd0);
      check_eq("rst_out_beats", 64'(out_beats), 64'd0);
      rst = 1'b0;
      tick();
      check_eq("rst_acc_ready", 64'(acc_ready), 64'd1);

      // Full word, back-to-back
      send(16'h1111);
      check_eq("full_rdy1", 64'(acc_ready), 64'd1);
      send(16'h2222);
      check_eq("full_rdy2", 64'(acc_ready), 64'd1);
      send(16'h3333);
      check_eq("full_rdy3", 64'(acc_ready), 64'd1);
      send(16'h4444);
      check_eq("full_lat0", 64'(out_valid), 64'd0);
      tick();
      check_eq("full_valid", 64'(out_valid), 64'd1);
      check_eq("full_data", out_data, 64'h4444_3333_2222_1111);
      check_eq("full_beats", 64'(out_beats), 64'd4);
      tick();

      // Explicit flush
      send(16'hAAAA);
      send(16'hBBBB);
      flush_pulse();
      check_eq("flush_lat0", 64'(out_valid), 64'd0);
      tick();
      check_eq("flush_valid", 64'(out_valid), 64'd1);
      check_eq("flush_data", out_data, 64'h0000_0000_BBBB_AAAA);
      check_eq("flush_beats", 64'(out_beats), 64'd2);
      tick();
      flush_pulse();
      repeat (4) tick();
      check_eq("flush_empty_words", 64'(n_words), 64'd2);
      check_eq("flush_empty_valid", 64'(out_valid), 64'd0);
`ifdef ACC_OUT_PACKER_STATS_EN
      check_eq("stat_words", 64'(stat_words), 64'd2);
      check_eq("stat_partial", 64'(stat_partial), 64'd1);
`endif

      // Backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(16'(32'hB000 + i));
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("bp_acc_ready", 64'(acc_ready), 64'd0);
         check_eq("bp_valid", 64'(out_valid), 64'd1);
         check_eq("bp_data", out_data, 64'hB003_B002_B001_B000);
         check_eq("bp_beats", 64'(out_beats), 64'd4);
      end
      out_ready = 1'b1;
      for (int i = 8; i < 12; i++) send(16'(32'hB000 + i));
      for (int c = 0; c < 50; c++) begin
         tick();
         if (exp_q.size() == 0 && !out_valid) break;
      end
      check_eq("bp_drained", 64'(exp_q.size()), 64'd0);
      check_eq("bp_words", 64'(n_words), 64'd5);

      // Idle timeout
      flush_cycles = 14'd5;
      send(16'h00CC);
      push_model();
      repeat (5) tick();
      check_eq("to_early", 64'(out_valid), 64'd0);
      tick();
      check_eq("to_valid", 64'(out_valid), 64'd1);
      check_eq("to_data", out_data, 64'h0000_0000_0000_00CC);
      check_eq("to_beats", 64'(out_beats), 64'd1);
      tick();
      flush_cycles = 14'd0;
      words_before = n_words;
      send(16'h00DD);
      repeat (1000) tick();
      check_eq("to_off_words", 64'(n_words), 64'(words_before));
      check_eq("to_off_valid", 64'(out_valid), 64'd0);
      flush_pulse();
      tick();
      check_eq("to_off_flush", out_data, 64'h0000_0000_0000_00DD);
      tick();

      // Reset mid-word; out_data still holds the 0xDD word here
      send(16'h5551);
      send(16'h5552);
      send(16'h5553);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
      check_eq("rst_mid_data", out_data, 64'd0);
      check_eq("rst_mid_beats", 64'(out_beats), 64'd0);
      m_acc = '0;
      m_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check_eq("rst_rel_ready", 64'(acc_ready), 64'd1);
      send(16'h6661);
      send(16'h6662);
      send(16'h6663);
      send(16'h6664);
      tick();
      check_eq("rst_new_valid", 64'(out_valid), 64'd1);
      check_eq("rst_new_data", out_data, 64'h6664_6663_6662_6661);
      for (int c = 0; c < 20; c++) begin
         tick();
         if (exp_q.size() == 0 && !out_valid) break;
      end
      check_eq("final_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
